// File: rtl/mask_builder_pkg.sv
// rtl/mask_builder_pkg.sv - shared types and defaults for the index-to-mask builder
package mask_builder_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_IDX_W = $clog2(DEF_WIDTH);

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_t;

endpackage

// File: rtl/mask_builder_idx_decoder.sv
// rtl/mask_builder_idx_decoder.sv - combinational index to one-hot decoder with range check
module idx_decoder
    import mask_builder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDX_W = DEF_IDX_W
) (
    input  logic [IDX_W-1:0] idx,
    output logic [WIDTH-1:0] onehot,
    output logic             in_range
);

    // Out-of-range indices only exist for non-power-of-2 widths; they decode to zero.
    always_comb begin
        in_range = ({1'b0, idx} < (IDX_W+1)'(WIDTH));
        onehot   = in_range ? (WIDTH'(1) << idx) : '0;
    end

endmodule

// File: rtl/mask_builder.sv
// rtl/mask_builder.sv - accumulates index beats into a mask; MASK_BUILDER_DUP_ERR_EN adds out_dup
module mask_builder
    import mask_builder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_idx,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_mask,
    output logic [IDX_W:0]   out_count
`ifdef MASK_BUILDER_DUP_ERR_EN
    ,
    output logic             out_dup
`endif
);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [IDX_W:0]   count;
    logic [WIDTH-1:0] onehot;
    logic             in_range;
    logic             is_new;
    logic [WIDTH-1:0] next_acc;
    logic [IDX_W:0]   next_count;

    idx_decoder #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_dec (
        .idx      (in_idx),
        .onehot   (onehot),
        .in_range (in_range)
    );

    always_comb begin
        is_new     = in_range && ((onehot & acc) == '0);
        next_acc   = acc | onehot;
        next_count = count + {{IDX_W{1'b0}}, is_new};
    end

`ifdef MASK_BUILDER_DUP_ERR_EN
    logic dup_seen;
    logic dup_hit;

    always_comb begin
        dup_hit = in_range && ((onehot & acc) != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dup_seen <= 1'b0;
            out_dup  <= 1'b0;
        end else if (state == COLLECT && in_valid) begin
            dup_seen <= dup_seen | dup_hit;
            if (in_last) begin
                out_dup <= dup_seen | dup_hit;
            end
        end else if (state == EMIT && out_ready) begin
            dup_seen <= 1'b0;
            out_dup  <= 1'b0;
        end
    end
`endif

    // in_ready/out_valid are registered copies of the state so no input reaches them combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= COLLECT;
            acc       <= '0;
            count     <= '0;
            out_mask  <= '0;
            out_count <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (in_valid) begin
                        acc   <= next_acc;
                        count <= next_count;
                        if (in_last) begin
                            out_mask  <= next_acc;
                            out_count <= next_count;
                            state     <= EMIT;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        acc       <= '0;
                        count     <= '0;
                        state     <= COLLECT;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= COLLECT;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mask_builder.sv
// tb/tb_mask_builder.sv - table-driven scoreboard bench for mask_builder
module tb_mask_builder;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_idx;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_mask;
    logic [3:0] out_count;
`ifdef MASK_BUILDER_DUP_ERR_EN
    logic       out_dup;
`endif

    mask_builder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_idx    (in_idx),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mask  (out_mask),
        .out_count (out_count)
`ifdef MASK_BUILDER_DUP_ERR_EN
        ,
        .out_dup   (out_dup)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         n;
        logic [2:0] idx [8];
        int         stall;
        logic [7:0] mask;
        logic [3:0] cnt;
        logic       dup;
    } vec_t;

    typedef struct {
        logic [7:0] mask;
        logic [3:0] cnt;
        logic       dup;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: compare the output whenever a transfer is about to happen.
    always @(negedge clk) begin
        if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 32'(out_mask), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_mask", 32'(out_mask), 32'(e.mask));
                chk("out_count", 32'(out_count), 32'(e.cnt));
`ifdef MASK_BUILDER_DUP_ERR_EN
                chk("out_dup", 32'(out_dup), 32'(e.dup));
`endif
            end
        end
    end

    task automatic send_beat(input logic [2:0] idx, input logic last);
        int bound;
        bound = 0;
        in_valid = 1'b1;
        in_idx   = idx;
        in_last  = last;
        while (in_ready !== 1'b1 && bound < 20) begin
            @(posedge clk); #1;
            bound++;
        end
        if (bound >= 20) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_frame(input vec_t v);
        int   bound;
        exp_t e;
        out_ready = (v.stall == 0);
        for (int b = 0; b < v.n; b++) begin
            if (b == v.n - 1) begin
                e.mask = v.mask; e.cnt = v.cnt; e.dup = v.dup;
                sb.push_back(e);
            end
            send_beat(v.idx[b], b == v.n - 1);
        end
        chk("latency_out_valid", 32'(out_valid), 32'd1);
        chk("emit_in_ready", 32'(in_ready), 32'd0);
        // Offer a beat during the stall; it must be refused and dropped.
        if (v.stall > 0) begin
            in_valid = 1'b1; in_idx = 3'd1; in_last = 1'b0;
        end
        for (int s = 0; s < v.stall; s++) begin
            @(posedge clk); #1;
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_mask", 32'(out_mask), 32'(v.mask));
        end
        out_ready = 1'b1;
        bound = 0;
        do begin
            @(posedge clk); #1;
            bound++;
        end while (out_valid === 1'b1 && bound < 20);
        in_valid = 1'b0;
        if (bound >= 20) chk("out_transfer_timeout", 32'(out_valid), 32'd0);
        chk("post_transfer_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        vecs[0] = '{n:3, idx:'{3'd0, 3'd3, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, stall:0, mask:8'h89, cnt:4'd3, dup:1'b0};
        vecs[1] = '{n:3, idx:'{3'd2, 3'd2, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, stall:0, mask:8'h24, cnt:4'd2, dup:1'b1};
        vecs[2] = '{n:1, idx:'{3'd6, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, stall:4, mask:8'h40, cnt:4'd1, dup:1'b0};
        vecs[3] = '{n:4, idx:'{3'd5, 3'd5, 3'd5, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0}, stall:0, mask:8'h20, cnt:4'd1, dup:1'b1};
        vecs[4] = '{n:8, idx:'{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}, stall:0, mask:8'hFF, cnt:4'd8, dup:1'b0};
        vecs[5] = '{n:5, idx:'{3'd7, 3'd0, 3'd7, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0}, stall:1, mask:8'h83, cnt:4'd3, dup:1'b1};

        reset = 1'b1; in_valid = 1'b0; in_idx = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_idle("reset");
        chk("reset_out_mask", 32'(out_mask), 32'h00);
        chk("reset_out_count", 32'(out_count), 32'd0);

        for (int i = 0; i < 6; i++) run_frame(vecs[i]);

        // Mid-frame reset discards the partial mask.
        send_beat(3'd1, 1'b0);
        send_beat(3'd4, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_idle("midreset");
        rv = '{n:1, idx:'{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, stall:0, mask:8'h01, cnt:4'd1, dup:1'b0};
        run_frame(rv);

        // Reset while a frame is waiting for the consumer.
        out_ready = 1'b0;
        send_beat(3'd3, 1'b1);
        chk("emit_before_reset", 32'(out_valid), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_idle("emitreset");
        chk("emitreset_out_mask", 32'(out_mask), 32'h00);

        // Random frames against a small reference model.
        for (int f = 0; f < 10; f++) begin
            rv.n = $urandom_range(1, 8);
            rv.stall = $urandom_range(0, 2);
            rv.mask = '0; rv.cnt = '0; rv.dup = 1'b0;
            for (int b = 0; b < 8; b++) rv.idx[b] = '0;
            for (int b = 0; b < rv.n; b++) begin
                rv.idx[b] = 3'($urandom_range(0, 7));
                if (rv.mask[rv.idx[b]]) rv.dup = 1'b1;
                else rv.cnt = rv.cnt + 4'd1;
                rv.mask[rv.idx[b]] = 1'b1;
            end
            run_frame(rv);
        end

        repeat (2) @(posedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
